// File: rtl/ahb_lite_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb_lite_slave_mem
//
// AHB-Lite memory-backed responder. Decodes a single address window of
// MEM_DEPTH 32-bit words starting at BASE_ADDR. It serves single and burst
// transfers beat by beat and inserts WAIT_STATES wait cycles into every OKAY
// data phase. Out-of-window, oversized or misaligned accesses get the
// two-cycle ERROR response. Writes land in a one-entry pending-write
// register and are committed to the array one cycle later. Reads see
// pending and in-flight write data merged over the array contents.
//
// Ports:
//   hclk          system clock
//   reset_active  asynchronous reset, active-high
//   hsel          slave select from the address decoder
//   haddr         byte address (address phase)
//   htrans        transfer type: IDLE/BUSY/NONSEQ/SEQ
//   hwrite        1 = write
//   hsize         000 byte, 001 half, 010 word
//   hburst        burst type (unused; every beat carries its own address)
//   hwdata        write data (data phase)
//   hready        bus-level HREADY
//   hreadyout     this slave's ready (registered)
//   hresp         00 OKAY, 01 ERROR (registered)
//   hrdata        read data (registered, held between transfers)
// ---------------------------------------------------------------------------
module ahb_lite_slave_mem #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  reset_active,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int unsigned           IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] WINDOW    = ADDR_WIDTH'(MEM_DEPTH * 4);
    localparam logic [3:0]            WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
    localparam logic [1:0]            RESP_OKAY  = 2'b00;
    localparam logic [1:0]            RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                  state;
    logic [3:0]              wait_cnt;

    // Latched address-phase information, kept in decoded form
    // (word index + byte strobes) instead of raw haddr/hsize.
    logic [IDX_W-1:0]        lat_idx;
    logic                    lat_write;
    logic [3:0]              lat_strb;

    // One-entry pending-write register.
    logic                    pend_valid;
    logic [IDX_W-1:0]        pend_idx;
    logic [DATA_WIDTH-1:0]   pend_data;
    logic [3:0]              pend_strb;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    accept;
    logic [ADDR_WIDTH-1:0]   offset;
    logic                    addr_err;
    logic                    bad_size;
    logic                    misaligned;
    logic [IDX_W-1:0]        req_idx;
    logic [3:0]              req_strb;
    logic                    wr_done;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic                    unused_ok;
    assign unused_ok = &{1'b0, hburst, htrans[0]};

    // hreadyout gating keeps a stray hready=1 during our own stalled
    // phases from starting a second access.
    assign accept  = hsel & hready & htrans[1] & hreadyout;
    assign offset  = haddr - BASE_ADDR;
    assign req_idx = offset[IDX_W+1:2];

    always_comb begin
        bad_size   = 1'b0;
        misaligned = 1'b0;
        req_strb   = 4'b0000;
        case (hsize)
            3'b000: req_strb = 4'b0001 << haddr[1:0];
            3'b001: begin
                misaligned = haddr[0];
                req_strb   = haddr[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                misaligned = |haddr[1:0];
                req_strb   = 4'b1111;
            end
            default: bad_size = 1'b1;
        endcase
    end

    // A base below BASE_ADDR wraps to a large offset, so one compare
    // covers both ends of the window.
    assign addr_err = (offset >= WINDOW) | bad_size | misaligned;

    // A write finishes on the edge that ends its DATA cycle; hwdata is
    // valid on the bus right now.
    assign wr_done = (state == ST_DATA) & lat_write;

    // Reads are evaluated either at acceptance (zero waits) or at the end
    // of the wait countdown, from the latched index.
    assign rd_idx = (state == ST_WAIT) ? lat_idx : req_idx;

    // Array word, overlaid by the pending write, overlaid by the write
    // completing on this very edge (newest data wins).
    always_comb begin
        rd_word = mem[rd_idx];
        for (int unsigned b = 0; b < 4; b++) begin
            if (pend_valid && (pend_idx == rd_idx) && pend_strb[b])
                rd_word[8*b +: 8] = pend_data[8*b +: 8];
            if (wr_done && (lat_idx == rd_idx) && lat_strb[b])
                rd_word[8*b +: 8] = hwdata[8*b +: 8];
        end
    end

    always_ff @(posedge hclk or posedge reset_active) begin
        if (reset_active) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            hreadyout  <= 1'b1;
            hresp      <= RESP_OKAY;
            hrdata     <= '0;
            lat_idx    <= '0;
            lat_write  <= 1'b0;
            lat_strb   <= '0;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            pend_data  <= '0;
            pend_strb  <= '0;
        end else begin
            if (wr_done) begin
                pend_valid <= 1'b1;
                pend_idx   <= lat_idx;
                pend_data  <= hwdata;
                pend_strb  <= lat_strb;
            end else begin
                pend_valid <= 1'b0;
            end

            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= ST_DATA;
                        hreadyout <= 1'b1;
                        hresp     <= RESP_OKAY;
                        if (!lat_write)
                            hrdata <= rd_word;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= RESP_ERROR;
                end

                default: begin
                    // IDLE, DATA and ERR2 all end with hreadyout=1, so a
                    // new address phase may be taken here back-to-back.
                    if (accept) begin
                        lat_idx  <= req_idx;
                        lat_strb <= req_strb;
                        if (addr_err) begin
                            state     <= ST_ERR1;
                            lat_write <= 1'b0;
                            hreadyout <= 1'b0;
                            hresp     <= RESP_ERROR;
                            if (!hwrite)
                                hrdata <= '0;
                        end else if (WAIT_STATES > 0) begin
                            state     <= ST_WAIT;
                            lat_write <= hwrite;
                            wait_cnt  <= WAIT_INIT;
                            hreadyout <= 1'b0;
                            hresp     <= RESP_OKAY;
                        end else begin
                            state     <= ST_DATA;
                            lat_write <= hwrite;
                            hreadyout <= 1'b1;
                            hresp     <= RESP_OKAY;
                            if (!hwrite)
                                hrdata <= rd_word;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        lat_write <= 1'b0;
                        hreadyout <= 1'b1;
                        hresp     <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

    // The array has no reset; pend_valid is cleared asynchronously, so a
    // write still pending at reset never reaches it.
    always_ff @(posedge hclk) begin
        if (pend_valid) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (pend_strb[b])
                    mem[pend_idx][8*b +: 8] <= pend_data[8*b +: 8];
            end
        end
    end

endmodule
